// File: rtl/tx_iq_pacer_if.sv
// rtl/tx_iq_pacer_if.sv - IQ sample input handshake and paced DAC output of tx_iq_pacer
`timescale 1ns/1ps
interface tx_iq_pacer_if;
   logic               iq_in_valid;
   logic signed [15:0] iq_in_i;
   logic signed [15:0] iq_in_q;
   logic               iq_in_ready;
   logic               dac_iq_valid;
   logic signed [15:0] dac_i;
   logic signed [15:0] dac_q;

   modport master (
      output iq_in_valid, iq_in_i, iq_in_q,
      input  iq_in_ready, dac_iq_valid, dac_i, dac_q
   );

   modport slave (
      input  iq_in_valid, iq_in_i, iq_in_q,
      output iq_in_ready, dac_iq_valid, dac_i, dac_q
   );
endinterface

// File: rtl/tx_iq_pacer.sv
// rtl/tx_iq_pacer.sv - prefilled IQ FIFO emitting one sample every DECIM clocks toward the DAC
// Optional per-packet counters sample_cnt/underrun_cnt when TX_IQ_PACER_STATS_EN is defined.
`timescale 1ns/1ps
module tx_iq_pacer #(
   parameter int FIFO_AW = 6,
   parameter int DECIM   = 10,
   parameter int PREFILL = 16
) (
   input  logic             clk,
   input  logic             phy_tx_arest,
   input  logic             phy_tx_start,
   input  logic             phy_tx_done,
   tx_iq_pacer_if.slave     io,
   output logic             pacer_busy,
   output logic             pacer_done,
   output logic             underrun,
   output logic [FIFO_AW:0] fifo_level
`ifdef TX_IQ_PACER_STATS_EN
   ,
   output logic [15:0]      sample_cnt,
   output logic [7:0]       underrun_cnt
`endif
);
   localparam int              DEPTH     = 1 << FIFO_AW;
   localparam int              LW        = FIFO_AW + 1;
   localparam logic [LW-1:0]   DEPTH_L   = LW'(DEPTH);
   localparam logic [LW-1:0]   PREFILL_L = LW'(PREFILL);
   localparam logic [7:0]      TICK_LAST = 8'(DECIM - 1);

   typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_STREAM} state_t;

   state_t             state_q, state_d;
   logic [7:0]         tick_q, tick_d;
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic               done_seen_q, done_seen_d;
   logic               underrun_q, underrun_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               pdone_q, pdone_d;
   logic               dvalid_q, dvalid_d;
   logic [31:0]        sample_q, sample_d;
   logic [31:0]        mem_q [DEPTH];
   logic               push;
   logic               pop;

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      done_seen_d = done_seen_q;
      underrun_d  = underrun_q;
      sample_d    = sample_q;
      dvalid_d    = 1'b0;
      pdone_d     = 1'b0;
      push        = io.iq_in_valid && ready_q;
      pop         = 1'b0;

      case (state_q)
         S_PREFILL: begin
            if (phy_tx_done) done_seen_d = 1'b1;
            if (level_q >= PREFILL_L || done_seen_q) begin
               state_d = S_STREAM;
               tick_d  = '0;
            end
         end
         S_STREAM: begin
            if (phy_tx_done) done_seen_d = 1'b1;
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (level_q != '0) begin
                  pop      = 1'b1;
                  dvalid_d = 1'b1;
                  sample_d = mem_q[rd_ptr_q];
               end else if (done_seen_q) begin
                  pdone_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  // keep the DAC clocked with silence rather than skipping a slot
                  dvalid_d   = 1'b1;
                  sample_d   = '0;
                  underrun_d = 1'b1;
               end
            end else begin
               tick_d = tick_q + 8'd1;
            end
         end
         default: ;
      endcase

      if (phy_tx_start) begin
         state_d     = S_PREFILL;
         tick_d      = '0;
         done_seen_d = 1'b0;
         underrun_d  = 1'b0;
         dvalid_d    = 1'b0;
         pdone_d     = 1'b0;
         sample_d    = sample_q;
         push        = 1'b0;
         pop         = 1'b0;
      end

      wr_ptr_d = phy_tx_start ? '0 : wr_ptr_q + FIFO_AW'(push);
      rd_ptr_d = phy_tx_start ? '0 : rd_ptr_q + FIFO_AW'(pop);
      level_d  = phy_tx_start ? '0 : level_q + LW'(push) - LW'(pop);
      busy_d   = (state_d != S_IDLE);
      // registered ready looks at the next level so it never admits a push into a full FIFO
      ready_d  = busy_d && (level_d < DEPTH_L);
   end

   always_ff @(posedge clk or posedge phy_tx_arest) begin
      if (phy_tx_arest) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         done_seen_q <= 1'b0;
         underrun_q  <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         pdone_q     <= 1'b0;
         dvalid_q    <= 1'b0;
         sample_q    <= '0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         done_seen_q <= done_seen_d;
         underrun_q  <= underrun_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         pdone_q     <= pdone_d;
         dvalid_q    <= dvalid_d;
         sample_q    <= sample_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {io.iq_in_i, io.iq_in_q};
   end

   assign io.iq_in_ready  = ready_q;
   assign io.dac_iq_valid = dvalid_q;
   assign io.dac_i        = sample_q[31:16];
   assign io.dac_q        = sample_q[15:0];
   assign pacer_busy      = busy_q;
   assign pacer_done      = pdone_q;
   assign underrun        = underrun_q;
   assign fifo_level      = level_q;

`ifdef TX_IQ_PACER_STATS_EN
   logic [15:0] sample_cnt_q, sample_cnt_d;
   logic [7:0]  urun_cnt_q, urun_cnt_d;
   logic        zero_fill;

   assign zero_fill = (state_q == S_STREAM) && (tick_q == TICK_LAST) && (level_q == '0)
                      && !done_seen_q && !phy_tx_start;

   always_comb begin
      sample_cnt_d = sample_cnt_q;
      urun_cnt_d   = urun_cnt_q;
      if (phy_tx_start) begin
         sample_cnt_d = '0;
         urun_cnt_d   = '0;
      end else begin
         if (pop) sample_cnt_d = sample_cnt_q + 16'd1;
         if (zero_fill && urun_cnt_q != 8'hFF) urun_cnt_d = urun_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge phy_tx_arest) begin
      if (phy_tx_arest) begin
         sample_cnt_q <= '0;
         urun_cnt_q   <= '0;
      end else begin
         sample_cnt_q <= sample_cnt_d;
         urun_cnt_q   <= urun_cnt_d;
      end
   end

   assign sample_cnt   = sample_cnt_q;
   assign underrun_cnt = urun_cnt_q;
`endif
endmodule

// File: tb/tb_tx_iq_pacer.sv
// tb/tb_tx_iq_pacer.sv - scoreboard bench for tx_iq_pacer (directed packets, paced output checks)
`timescale 1ns/1ps
module tb_tx_iq_pacer;
   localparam int DECIM = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       done = 1'b0;
   logic       pacer_busy, pacer_done, underrun;
   logic [6:0] fifo_level;
`ifdef TX_IQ_PACER_STATS_EN
   logic [15:0] sample_cnt;
   logic [7:0]  underrun_cnt;
`endif

   tx_iq_pacer_if iq();

   tx_iq_pacer #(.FIFO_AW(6), .DECIM(DECIM), .PREFILL(16)) dut (
      .clk          (clk),
      .phy_tx_arest (rst),
      .phy_tx_start (start),
      .phy_tx_done  (done),
      .io           (iq),
      .pacer_busy   (pacer_busy),
      .pacer_done   (pacer_done),
      .underrun     (underrun),
      .fifo_level   (fifo_level)
`ifdef TX_IQ_PACER_STATS_EN
      ,
      .sample_cnt   (sample_cnt),
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #2.5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   int          cycle = 0;
   int          last_strobe = -1;
   int          strobes = 0;
   int          zero_strobes = 0;
   int          done_pulses = 0;
   int          max_level = 0;
   bit          full_stall_seen = 1'b0;
   bit          allow_zero = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   // monitor: pops the scoreboard on every strobe; a start pulse discards what the DUT flushes
   always @(negedge clk) begin
      if (!rst) begin
         if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
         if (fifo_level == 7'd64 && !iq.iq_in_ready) full_stall_seen = 1'b1;
         if (iq.dac_iq_valid) begin
            if (last_strobe >= 0) chk("strobe_spacing", cycle - last_strobe, DECIM);
            last_strobe = cycle;
            strobes++;
            if (allow_zero && iq.dac_i == 16'sd0 && iq.dac_q == 16'sd0) begin
               zero_strobes++;
            end else if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 1, 0);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               chk("sample", {iq.dac_i, iq.dac_q}, e);
            end
         end
         if (pacer_done) begin
            done_pulses++;
            if (last_strobe >= 0) chk("done_spacing", cycle - last_strobe, DECIM);
            chk("busy_falls_with_done", pacer_busy, 0);
            chk("no_strobe_with_done", iq.dac_iq_valid, 0);
         end
         if (start) begin
            exp_q.delete();
            last_strobe     = -1;
            strobes         = 0;
            zero_strobes    = 0;
            done_pulses     = 0;
            max_level       = 0;
            full_stall_seen = 1'b0;
         end
      end
   end

   // all stimulus tasks are entered 1 ns after a rising edge
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_done();
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
   endtask

   task automatic push(input logic [15:0] i, input logic [15:0] q);
      int n = 0;
      iq.iq_in_valid = 1'b1;
      iq.iq_in_i     = i;
      iq.iq_in_q     = q;
      @(negedge clk);
      while (!iq.iq_in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!iq.iq_in_ready) chk("push_timeout", 0, 1);
      exp_q.push_back({i, q});
      @(posedge clk); #1;
      iq.iq_in_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      @(negedge clk);
      while (!pacer_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("pacer_done_seen", pacer_done, 1);
      chk("drain_empty", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      iq.iq_in_valid = 1'b0;
      iq.iq_in_i     = '0;
      iq.iq_in_q     = '0;
      #1 rst = 1'b1;
      #9;
      chk("rst_ready",     iq.iq_in_ready, 0);
      chk("rst_dac_valid", iq.dac_iq_valid, 0);
      chk("rst_dac_iq",    {iq.dac_i, iq.dac_q}, 0);
      chk("rst_busy",      pacer_busy, 0);
      chk("rst_done",      pacer_done, 0);
      chk("rst_underrun",  underrun, 0);
      chk("rst_level",     fifo_level, 0);
      #11 rst = 1'b0;
      @(posedge clk); #1;

      // ramp packet: 100 samples then done
      pulse_start();
      @(negedge clk);
      chk("start_ready", iq.iq_in_ready, 1);
      chk("start_busy",  pacer_busy, 1);
      chk("start_level", fifo_level, 0);
      @(posedge clk); #1;
      for (int n = 0; n < 100; n++) push(16'(n), 16'(-n));
      pulse_done();
      wait_done(3000);
      chk("ramp_strobes", strobes, 100);
      chk("ramp_underrun", underrun, 0);
      chk("ramp_done_pulses", done_pulses, 1);
`ifdef TX_IQ_PACER_STATS_EN
      chk("ramp_sample_cnt", sample_cnt, 100);
      chk("ramp_underrun_cnt", underrun_cnt, 0);
`endif

      // overfill: 80 back-to-back samples saturate the FIFO
      pulse_start();
      for (int n = 0; n < 80; n++) push(16'(500 + n), 16'(-(500 + n)));
      pulse_done();
      wait_done(3000);
      chk("fill_max_level", max_level, 64);
      chk("fill_ready_low_at_full", full_stall_seen, 1);
      chk("fill_strobes", strobes, 80);
      chk("fill_underrun", underrun, 0);

      // short packet below prefill threshold
      pulse_start();
      for (int n = 0; n < 5; n++) push(16'(700 + n), 16'(n));
      wait_cycles(30);
      chk("short_no_stream_before_done", strobes, 0);
      pulse_done();
      wait_done(500);
      chk("short_strobes", strobes, 5);
      chk("short_done_pulses", done_pulses, 1);

      // gap: upstream stalls mid-packet, zero fill expected
      pulse_start();
      allow_zero = 1'b1;
      for (int n = 0; n < 20; n++) push(16'(1000 + n), 16'(-(1000 + n)));
      wait_cycles(300);
      for (int n = 20; n < 40; n++) push(16'(1000 + n), 16'(-(1000 + n)));
      pulse_done();
      wait_done(3000);
      allow_zero = 1'b0;
      chk("gap_underrun", underrun, 1);
      chk("gap_zero_strobes_present", (zero_strobes > 0) ? 1 : 0, 1);
      chk("gap_total_strobes", strobes, 40 + zero_strobes);
`ifdef TX_IQ_PACER_STATS_EN
      chk("gap_underrun_cnt", underrun_cnt, zero_strobes);
      chk("gap_sample_cnt", sample_cnt, 40);
`endif

      // restart mid-stream with data buffered and underrun already flagged
      pulse_start();
      allow_zero = 1'b1;
      for (int n = 0; n < 16; n++) push(16'(2000 + n), 16'(n));
      wait_cycles(300);
      chk("restart_pre_underrun", underrun, 1);
      for (int n = 0; n < 34; n++) push(16'(3000 + n), 16'(n));
      begin
         int n = 0;
         @(negedge clk);
         while (fifo_level > 7'd30 && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk("restart_level_reached", (fifo_level <= 7'd30) ? 1 : 0, 1);
      end
      @(posedge clk); #1;
      allow_zero = 1'b0;
      pulse_start();
      @(negedge clk);
      chk("restart_level_zero", fifo_level, 0);
      chk("restart_underrun_clear", underrun, 0);
      chk("restart_busy", pacer_busy, 1);
      @(posedge clk); #1;
      for (int n = 0; n < 10; n++) push(16'(4000 + n), 16'(-n));
      pulse_done();
      wait_done(1000);
      chk("restart_strobes", strobes, 10);
      chk("restart_underrun_end", underrun, 0);
`ifdef TX_IQ_PACER_STATS_EN
      chk("restart_sample_cnt", sample_cnt, 10);
      chk("restart_underrun_cnt", underrun_cnt, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
